hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/sb_counter.sv | 27 ++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the hazard scoreboard.
//   CNT_W     : width of each per-register wait counter
//   LAT_*     : wait cycles loaded into a destination counter on issue
//   NUM_REGS  : architectural register count (x0 is hard-wired zero)
//   id_req_t  : hazard-relevant fields of the instruction sitting in ID
//   issue_lat : picks the wait latency for an issuing producer
package pipeline_pkg;

  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 32;

  localparam logic [CNT_W-1:0] LAT_ALU  = 2'd0;
  localparam logic [CNT_W-1:0] LAT_LOAD = 2'd1;
  localparam logic [CNT_W-1:0] LAT_MUL  = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic       esc_reg_n;  // 0 = instruction writes rd
    logic       is_load;
    logic       is_mul;
  } id_req_t;

  // Load wins over multiply when both flags are set.
  function automatic logic [CNT_W-1:0] issue_lat(input logic is_load, input logic is_mul);
    if (is_load)     return LAT_LOAD;
    else if (is_mul) return LAT_MUL;
    else             return LAT_ALU;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One register's wait counter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : producer to this register issues this cycle
//   load_val     : latency to start counting from
//   busy         : counter nonzero (register still pending)
// Load takes priority over the per-cycle decrement.
module sb_counter
  import pipeline_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for the ID stage.
// Tracks, per register x1..x31, how many more cycles a producer's result is
// unavailable via forwarding, and stalls a consumer until it is.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   validID             : ID holds a real instruction
//   rs1, rs2            : source indices; useRs1/useRs2 qualify them
//   rdID, EscRegID      : destination and active-low write enable
//   isLoadID            : instruction is a load
//   isMulID             : instruction is a multiply (HAZARD_MULDIV_EN only)
//   stall               : hold PC and IF/ID, bubble into ID/EX (combinational)
//   pendingMask         : bit r set while register r has a nonzero count
//   stallCount          : saturating count of stalled cycles since reset
// Build option: define HAZARD_MULDIV_EN to add isMulID and multiply latency;
// otherwise multiplies are treated as single-cycle ALU ops.
module hazard_scoreboard
  import pipeline_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        validID,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        useRs1,
  input  logic        useRs2,
  input  logic [4:0]  rdID,
  input  logic        EscRegID,
  input  logic        isLoadID,
`ifdef HAZARD_MULDIV_EN
  input  logic        isMulID,
`endif
  output logic        stall,
  output logic [31:0] pendingMask,
  output logic [15:0] stallCount
);

  id_req_t                req;
  logic [NUM_REGS-1:0]    busy;
  logic [NUM_REGS-1:0]    load;
  logic [CNT_W-1:0]       lat;
  logic                   issue;
  logic                   wr_en;
  logic [15:0]            stall_cnt;

  always_comb begin
    req.valid     = validID;
    req.rs1       = rs1;
    req.rs2       = rs2;
    req.use_rs1   = useRs1;
    req.use_rs2   = useRs2;
    req.rd        = rdID;
    req.esc_reg_n = EscRegID;
    req.is_load   = isLoadID;
`ifdef HAZARD_MULDIV_EN
    req.is_mul    = isMulID;
`else
    req.is_mul    = 1'b0;
`endif
  end

  // Stall reads the pre-edge counters, so rs==rd sees the old producer.
  assign stall = req.valid & ((req.use_rs1 & busy[req.rs1]) |
                              (req.use_rs2 & busy[req.rs2]));
  assign issue = req.valid & ~stall;
  assign wr_en = issue & ~req.esc_reg_n & (req.rd != 5'd0);
  assign lat   = issue_lat(req.is_load, req.is_mul);

  // x0 is never tracked.
  assign busy[0] = 1'b0;
  assign load[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    assign load[r] = wr_en & (req.rd == 5'(r));
    sb_counter u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (load[r]),
      .load_val (lat),
      .busy     (busy[r])
    );
  end

  assign pendingMask = busy;

  always_ff @(posedge clock) begin
    if (reset)                          stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign stallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table plus
// hand-written reset-mid-stall and stall-counter saturation sequences.
module tb_hazard_scoreboard;

`ifdef HAZARD_MULDIV_EN
  localparam int MUL_ON = 1;
`else
  localparam int MUL_ON = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        validID;
  logic [4:0]  rs1, rs2, rdID;
  logic        useRs1, useRs2, EscRegID, isLoadID;
`ifdef HAZARD_MULDIV_EN
  logic        isMulID;
`endif
  logic        stall;
  logic [31:0] pendingMask;
  logic [15:0] stallCount;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .validID     (validID),
    .rs1         (rs1),
    .rs2         (rs2),
    .useRs1      (useRs1),
    .useRs2      (useRs2),
    .rdID        (rdID),
    .EscRegID    (EscRegID),
    .isLoadID    (isLoadID),
`ifdef HAZARD_MULDIV_EN
    .isMulID     (isMulID),
`endif
    .stall       (stall),
    .pendingMask (pendingMask),
    .stallCount  (stallCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        esc;
    logic        ld;
    logic        mul;
    logic        e_stall;
    logic [31:0] e_mask;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic v, logic [4:0] a, logic ua, logic [4:0] b, logic ub,
                              logic [4:0] d, logic esc, logic ld, logic mul,
                              logic es, logic [31:0] em, logic [15:0] ec);
    vec_t t;
    t.v = v; t.rs1 = a; t.u1 = ua; t.rs2 = b; t.u2 = ub; t.rd = d;
    t.esc = esc; t.ld = ld; t.mul = mul;
    t.e_stall = es; t.e_mask = em; t.e_cnt = ec;
    return t;
  endfunction

  function automatic logic [31:0] bit_of(int r);
    logic [31:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t t);
    validID  = t.v;
    rs1      = t.rs1;
    useRs1   = t.u1;
    rs2      = t.rs2;
    useRs2   = t.u2;
    rdID     = t.rd;
    EscRegID = t.esc;
    isLoadID = t.ld;
`ifdef HAZARD_MULDIV_EN
    isMulID  = t.mul;
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] c;
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Fields: v, rs1, u1, rs2, u2, rd, esc, ld, mul | stall, mask, stallCount
    // Each row's expectations are sampled before that row's clock edge.
    tv.push_back(mk(0,  0,0,  0,0,  0,1,0,0,  0, 0, 0));                 // reset state
    tv.push_back(mk(1,  1,1,  2,1,  5,0,0,0,  0, 0, 0));                 // ALU x5
    tv.push_back(mk(1,  5,1,  2,1,  9,0,0,0,  0, 0, 0));                 // reads x5, no stall
    tv.push_back(mk(1,  1,1,  0,0,  6,0,1,0,  0, 0, 0));                 // LW x6
    tv.push_back(mk(1,  6,1,  3,1, 10,0,0,0,  1, bit_of(6), 0));         // load-use stall
    tv.push_back(mk(1,  6,1,  3,1, 10,0,0,0,  0, 0, 1));                 // issues
    tv.push_back(mk(1,  1,1,  0,0,  0,0,1,0,  0, 0, 1));                 // LW x0
    tv.push_back(mk(1,  0,1,  0,1, 11,0,0,0,  0, 0, 1));                 // reads x0
    tv.push_back(mk(1,  1,1,  0,0, 12,0,1,0,  0, 0, 1));                 // LW x12
    tv.push_back(mk(1, 12,0,  4,1, 13,0,0,0,  0, bit_of(12), 1));        // rs1 unused
    tv.push_back(mk(1,  1,1,  0,0, 14,0,1,0,  0, 0, 1));                 // LW x14
    tv.push_back(mk(0, 14,1, 14,1, 19,0,1,0,  0, bit_of(14), 1));        // invalid ID
    tv.push_back(mk(1, 14,1,  0,0, 19,0,0,0,  0, 0, 1));                 // x14 drained
    tv.push_back(mk(1,  1,1,  0,0, 15,1,1,0,  0, 0, 1));                 // LW, no write
    tv.push_back(mk(1, 15,1,  0,0, 19,0,0,0,  0, 0, 1));                 // x15 never pending
    tv.push_back(mk(1, 16,1,  0,0, 16,0,1,0,  0, 0, 1));                 // LW x16 <- x16
    tv.push_back(mk(1, 16,1,  0,0, 16,0,1,0,  1, bit_of(16), 1));        // old count stalls
    tv.push_back(mk(1, 16,1,  0,0, 16,0,1,0,  0, 0, 2));                 // issues, reloads
    tv.push_back(mk(0,  0,0,  0,0,  0,1,0,0,  0, bit_of(16), 2));
    tv.push_back(mk(0,  0,0,  0,0,  0,1,0,0,  0, 0, 2));
    tv.push_back(mk(1,  1,1,  0,0, 17,0,1,1,  0, 0, 2));                 // load+mul -> LAT_LOAD
    tv.push_back(mk(1,  0,0, 17,1, 22,0,0,0,  1, bit_of(17), 2));
    tv.push_back(mk(1,  0,0, 17,1, 22,0,0,0,  0, 0, 3));
    tv.push_back(mk(1,  1,1,  2,1,  7,0,0,1,  0, 0, 3));                 // MUL x7
    tv.push_back(mk(1,  7,1,  0,0, 18,0,0,0,  MUL_ON[0], MUL_ON ? bit_of(7) : 0, 3));
    tv.push_back(mk(1,  7,1,  0,0, 18,0,0,0,  MUL_ON[0], MUL_ON ? bit_of(7) : 0, 16'(3 + MUL_ON)));
    c = 16'(3 + 2 * MUL_ON);
    tv.push_back(mk(0,  0,0,  0,0,  0,1,0,0,  0, 0, c));
    tv.push_back(mk(1,  1,1,  0,0, 20,0,1,0,  0, 0, c));                 // LW x20
    tv.push_back(mk(1,  1,1,  0,0, 20,0,1,0,  0, bit_of(20), c));        // reload beats decrement
    tv.push_back(mk(1, 20,1,  0,0, 21,0,0,0,  1, bit_of(20), c));
    tv.push_back(mk(1, 20,1,  0,0, 21,0,0,0,  0, 0, c + 16'd1));

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clock);
      apply(tv[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, tv[i].e_stall});
      chk($sformatf("v%0d_mask", i), pendingMask, tv[i].e_mask);
      chk($sformatf("v%0d_cnt", i), {16'd0, stallCount}, {16'd0, tv[i].e_cnt});
    end

    // Reset asserted during a load-use stall discards the pending wait.
    do_reset();
    @(negedge clock);
    apply(mk(1, 1,1, 0,0, 8,0,1,0, 0,0,0));                                // LW x8
    @(negedge clock);
    apply(mk(1, 8,1, 0,0, 23,0,0,0, 0,0,0));                               // dependent
    #1;
    chk("rst_pre_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mask", pendingMask, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cnt", {16'd0, stallCount}, 32'd0);

    // Saturation: preload the stall counter near the top, then stall 3 times.
    do_reset();
    @(negedge clock);
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      apply(mk(1, 1,1, 0,0, 24,0,1,0, 0,0,0));                             // LW x24
      @(negedge clock);
      apply(mk(1, 24,1, 0,0, 25,0,0,0, 0,0,0));                            // stalls once
      #1;
      chk($sformatf("sat%0d_stall", k), {31'd0, stall}, 32'd1);
      @(negedge clock);
      apply(mk(0, 0,0, 0,0, 0,1,0,0, 0,0,0));
      #1;
      chk($sformatf("sat%0d_cnt", k), {16'd0, stallCount},
          (k == 0) ? 32'h0000FFFE : 32'h0000FFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
